// File: rtl/axil_dmem_slave.sv
// rtl/axil_dmem_slave.sv - AXI4-Lite slave fronting a byte-writable word memory
//
// Purpose: exposes DEPTH_WORDS x 32-bit storage at BASE_ADDR through an
// AXI4-Lite slave. Independent write and read FSMs; one read every two
// cycles with 1-cycle latency; out-of-range accesses return SLVERR.
//
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   awvalid/awready/awaddr  write address channel
//   wvalid/wready/wdata/wstrb write data channel
//   bvalid/bready/bresp     write response channel
//   arvalid/arready/araddr  read address channel
//   rvalid/rready/rdata/rresp read data channel

module axil_dmem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [31:0] aw_q;
  logic [31:0] wd_q;
  logic [3:0]  ws_q;
  logic [31:0] mem_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        aw_hs, w_hs, ar_hs;
  logic        commit;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] wr_off, rd_off;
  logic        wr_ok, rd_ok;
  logic [AW-1:0] wr_idx, rd_idx;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  // Whichever half arrived first is taken from its holding register, the
  // other half straight from the bus on the completing edge.
  assign wr_addr = (w_state == W_ADDR) ? aw_q : awaddr;
  assign wr_data = (w_state == W_DATA) ? wd_q : wdata;
  assign wr_strb = (w_state == W_DATA) ? ws_q : wstrb;

  assign commit = ((w_state == W_IDLE) && aw_hs && w_hs) ||
                  ((w_state == W_ADDR) && w_hs) ||
                  ((w_state == W_DATA) && aw_hs);

  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = araddr - BASE_ADDR;
  assign wr_ok  = (wr_addr >= BASE_ADDR) && ((wr_off >> 2) < DEPTH_W);
  assign rd_ok  = (araddr >= BASE_ADDR) && ((rd_off >> 2) < DEPTH_W);
  assign wr_idx = wr_off[AW+1:2];
  assign rd_idx = rd_off[AW+1:2];

  // Read data is only presented for a successful read; this also keeps rdata
  // at zero through reset without resetting the RAM output register.
  assign rdata = (rvalid && (rresp == OKAY)) ? mem_q : 32'h0;

  // Storage: one write port, one registered read port, read-first ordering
  // so a same-edge read sees the pre-write word. Not reset.
  always_ff @(posedge aclk) begin
    if (commit && wr_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_strb[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
    if (ar_hs) mem_q <= mem[rd_idx];
  end

  // Write FSM. The readys are registered, so they come up on the first edge
  // after reset release rather than while reset is still asserted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      aw_q    <= 32'h0;
      wd_q    <= 32'h0;
      ws_q    <= 4'h0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs) begin
            w_state <= W_RESP;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_ok ? OKAY : SLVERR;
          end else if (aw_hs) begin
            w_state <= W_ADDR;
            aw_q    <= awaddr;
            awready <= 1'b0;
            wready  <= 1'b1;
          end else if (w_hs) begin
            w_state <= W_DATA;
            wd_q    <= wdata;
            ws_q    <= wstrb;
            awready <= 1'b1;
            wready  <= 1'b0;
          end else begin
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        W_ADDR: begin
          if (w_hs) begin
            w_state <= W_RESP;
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_ok ? OKAY : SLVERR;
          end
        end
        W_DATA: begin
          if (aw_hs) begin
            w_state <= W_RESP;
            awready <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= wr_ok ? OKAY : SLVERR;
          end
        end
        W_RESP: begin
          if (bready) begin
            w_state <= W_IDLE;
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rresp   <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state <= R_RESP;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rresp   <= rd_ok ? OKAY : SLVERR;
          end else begin
            arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (rready) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            arready <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_dmem_slave.sv
// tb/tb_axil_dmem_slave.sv - directed self-checking bench for axil_dmem_slave

module tb_axil_dmem_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  axil_dmem_slave dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " outs"},
             {24'h0, awready, wready, arready, bvalid, rvalid, 3'b0}, 32'h0);
    check_eq({tag, " resp"}, {28'h0, bresp, rresp}, 32'h0);
    check_eq({tag, " rdata"}, rdata, 32'h0);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input string tag);
    awvalid = 1'b1; awaddr = addr;
    wvalid  = 1'b1; wdata = data; wstrb = strb;
    bready  = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq({tag, " bvalid"}, {31'h0, bvalid}, 32'h1);
    check_eq({tag, " bresp"}, {30'h0, bresp}, {30'h0, exp_resp});
    tick();
    bready = 1'b0;
    check_eq({tag, " bvalid done"}, {31'h0, bvalid}, 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string tag);
    arvalid = 1'b1; araddr = addr;
    rready  = 1'b1;
    tick();
    arvalid = 1'b0;
    check_eq({tag, " rvalid"}, {31'h0, rvalid}, 32'h1);
    check_eq({tag, " rdata"}, rdata, exp_data);
    check_eq({tag, " rresp"}, {30'h0, rresp}, {30'h0, exp_resp});
    tick();
    rready = 1'b0;
    check_eq({tag, " rvalid done"}, {31'h0, rvalid}, 32'h0);
  endtask

  initial begin
    areset = 1'b1;
    awvalid = 1'b0; awaddr = 32'h0;
    wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
    bready = 1'b0;
    arvalid = 1'b0; araddr = 32'h0;
    rready = 1'b0;

    // Reset state
    #3;
    check_all_zero("reset t0");
    tick(); tick();
    check_all_zero("reset held");
    @(negedge aclk);
    areset = 1'b0;
    tick();
    check_eq("readys after release", {29'h0, awready, wready, arready}, 32'h7);

    // Same-cycle AW+W then read back
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00, "wr10");
    axi_read(32'h10, 32'hDEAD_BEEF, 2'b00, "rd10");

    // W three cycles ahead of AW, partial strobes
    bready = 1'b1;
    wvalid = 1'b1; wdata = 32'h1122_3344; wstrb = 4'b0101;
    tick();
    wvalid = 1'b0;
    check_eq("wdata state readys", {30'h0, awready, wready}, 32'h2);
    tick(); tick();
    check_eq("wdata held readys", {30'h0, awready, wready}, 32'h2);
    awvalid = 1'b1; awaddr = 32'h10;
    tick();
    awvalid = 1'b0;
    check_eq("late aw bvalid", {31'h0, bvalid}, 32'h1);
    check_eq("late aw bresp", {30'h0, bresp}, 32'h0);
    tick();
    bready = 1'b0;
    axi_read(32'h10, 32'hDE22_BE44, 2'b00, "rd strb");

    // Out of range, word 0 must not be hit by wrap-around
    axi_write(32'h0, 32'h0102_0304, 4'hF, 2'b00, "wr0");
    axi_write(32'h1000, 32'hFFFF_FFFF, 4'hF, 2'b10, "wr oor");
    axi_read(32'h1000, 32'h0, 2'b10, "rd oor");
    axi_read(32'h0, 32'h0102_0304, 2'b00, "rd0 intact");
    axi_read(32'h10, 32'hDE22_BE44, 2'b00, "rd10 intact");

    // Last in-range word, and a zero-strobe write
    axi_write(32'hFFC, 32'hA5A5_0FF0, 4'hF, 2'b00, "wr last");
    axi_read(32'hFFF, 32'hA5A5_0FF0, 2'b00, "rd last");
    axi_write(32'h10, 32'h0BAD_0BAD, 4'h0, 2'b00, "wr strb0");
    axi_read(32'h10, 32'hDE22_BE44, 2'b00, "rd strb0");

    // Backpressure on both response channels
    awvalid = 1'b1; awaddr = 32'h30;
    wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 32'h10;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall bvalid", {31'h0, bvalid}, 32'h1);
      check_eq("stall bresp", {30'h0, bresp}, 32'h0);
      check_eq("stall rvalid", {31'h0, rvalid}, 32'h1);
      check_eq("stall rdata", rdata, 32'hDE22_BE44);
      check_eq("stall rresp", {30'h0, rresp}, 32'h0);
      check_eq("stall readys", {29'h0, awready, wready, arready}, 32'h0);
      tick();
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    check_eq("stall release valids", {30'h0, bvalid, rvalid}, 32'h0);
    check_eq("stall release readys", {29'h0, awready, wready, arready}, 32'h7);
    bready = 1'b0; rready = 1'b0;
    axi_read(32'h30, 32'hCAFE_F00D, 2'b00, "rd30");

    // Same-edge write commit and read of word 4
    axi_write(32'h10, 32'h5555_5555, 4'hF, 2'b00, "wr55");
    bready = 1'b1; rready = 1'b1;
    wvalid = 1'b1; wdata = 32'hAAAA_AAAA; wstrb = 4'hF;
    tick();
    wvalid = 1'b0;
    awvalid = 1'b1; awaddr = 32'h10;
    arvalid = 1'b1; araddr = 32'h10;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check_eq("rbw bvalid", {31'h0, bvalid}, 32'h1);
    check_eq("rbw rvalid", {31'h0, rvalid}, 32'h1);
    check_eq("rbw rdata", rdata, 32'h5555_5555);
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(32'h10, 32'hAAAA_AAAA, 2'b00, "rbw after");

    // Reset in W_ADDR and R_RESP
    axi_write(32'h20, 32'h1234_5678, 4'hF, 2'b00, "wr20");
    awvalid = 1'b1; awaddr = 32'h20;
    arvalid = 1'b1; araddr = 32'h20;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    check_eq("pre-reset state", {28'h0, awready, wready, rvalid, bvalid}, 32'h6);
    #2;
    areset = 1'b1;
    #1;
    check_all_zero("reset mid");
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    tick(); tick();
    check_all_zero("reset mid held");
    wvalid = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    tick();
    check_eq("readys after reset2", {29'h0, awready, wready, arready}, 32'h7);
    check_eq("valids after reset2", {30'h0, bvalid, rvalid}, 32'h0);
    axi_read(32'h20, 32'h1234_5678, 2'b00, "rd20 intact");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
